jamma_db9_scanner: RTL

//  Sequencer for the JAMMA/DB9 serial joystick chain on Neptuno2: drives JOY_LOAD/JOY_CLK of the external
//  74HC165-style shift register, samples JOY_DATA, and publishes two debounced-free 12-bit player words.

---
 rtl/jamma_db9_scanner_if.sv | 23 ++
 rtl/jamma_db9_scanner.sv | 115 +++++++++++
 2 files changed

// File: rtl/jamma_db9_scanner_if.sv
// Pin and player-word bundle between the DB9/JAMMA chain scanner and its consumers.
// The scanner side is master; the board pins / input mapping side is slave.
interface jamma_db9_scanner_if;
   logic        enable;
   logic        joy_data;
   logic        joy_clk;
   logic        joy_load;
   logic        joy_select;
   logic [11:0] joy1;
   logic [11:0] joy2;
   logic        frame_valid;
   logic        busy;

   modport master (
      input  enable, joy_data,
      output joy_clk, joy_load, joy_select, joy1, joy2, frame_valid, busy
   );

   modport slave (
      output enable, joy_data,
      input  joy_clk, joy_load, joy_select, joy1, joy2, frame_valid, busy
   );
endinterface

// File: rtl/jamma_db9_scanner.sv
// Scans the external 74HC165-style joystick chain: load, 24 shifted bits, idle gap,
// and publishes two active-high 12-bit player words with a one-cycle frame_valid.
module jamma_db9_scanner #(
   parameter int unsigned CLK_DIV   = 8,
   parameter int unsigned GAP_TICKS = 16
) (
   input  logic                clk_sys,
   input  logic                reset,
   jamma_db9_scanner_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  div_cnt;
   logic        tick;
   logic [1:0]  data_sync;
   logic        data_s;
   logic [7:0]  gap_cnt;
   logic        gap_full;
   logic        gap_hit;
   logic        load_cnt;
   logic [4:0]  bit_idx;
   logic        phase;
   logic [23:0] raw;
   logic        load_nxt;
   logic        clk_nxt;

   always_ff @(posedge clk_sys) begin
      if (reset || tick) div_cnt <= '0;
      else               div_cnt <= div_cnt + 8'd1;
   end

   assign tick = (div_cnt == 8'(CLK_DIV - 1));

   always_ff @(posedge clk_sys) begin
      if (reset) data_sync <= '1;
      else       data_sync <= {data_sync[0], bus.joy_data};
   end

   assign data_s   = data_sync[1];
   assign gap_full = (gap_cnt >= 8'(GAP_TICKS));
   // Counting the tick that performs the transition keeps the gap at exactly GAP_TICKS ticks.
   assign gap_hit  = (({1'b0, gap_cnt} + 9'd1) >= 9'(GAP_TICKS));

   always_ff @(posedge clk_sys) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (tick && bus.enable && gap_hit)           state_nxt = S_LOAD;
         S_LOAD:  if (tick && load_cnt)                        state_nxt = S_SHIFT;
         S_SHIFT: if (tick && phase && (bit_idx == 5'd23))     state_nxt = S_DONE;
         S_DONE:                                               state_nxt = S_IDLE;
         default:                                              state_nxt = S_IDLE;
      endcase
   end

   // Gap preset on reset so the first load is issued on the very first tick.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         gap_cnt  <= 8'(GAP_TICKS);
         load_cnt <= 1'b0;
         bit_idx  <= '0;
         phase    <= 1'b0;
         raw      <= '0;
      end else if (tick) begin
         case (state)
            S_IDLE: begin
               load_cnt <= 1'b0;
               if (state_nxt == S_LOAD) gap_cnt <= '0;
               else if (!gap_full)      gap_cnt <= gap_cnt + 8'd1;
            end
            S_LOAD: begin
               load_cnt <= 1'b1;
               bit_idx  <= '0;
               phase    <= 1'b0;
            end
            S_SHIFT: begin
               phase <= ~phase;
               if (!phase) raw[bit_idx] <= data_s;
               else        bit_idx      <= bit_idx + 5'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      load_nxt       = (state != S_LOAD);
      clk_nxt        = (state == S_SHIFT) && phase;
      bus.busy       = (state == S_LOAD) || (state == S_SHIFT);
      bus.joy_select = 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bus.joy_clk     <= 1'b0;
         bus.joy_load    <= 1'b1;
         bus.joy1        <= '0;
         bus.joy2        <= '0;
         bus.frame_valid <= 1'b0;
      end else begin
         bus.joy_clk     <= clk_nxt;
         bus.joy_load    <= load_nxt;
         bus.frame_valid <= (state == S_DONE);
         if (state == S_DONE) begin
            bus.joy1 <= ~raw[11:0];
            bus.joy2 <= ~raw[23:12];
         end
      end
   end
endmodule
